// File: rtl/mem_req_queue.sv
// Dual-issue, in-order memory request queue feeding a single memory stage.
// Optional build macro MEM_REQ_ADDR_CHECK_EN rejects addresses outside the 32-word data memory.
module mem_req_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in0_valid,
    input  logic        in1_valid,
    input  logic        in0_isld,
    input  logic        in0_isst,
    input  logic        in1_isld,
    input  logic        in1_isst,
    input  logic [15:0] in0_addr,
    input  logic [15:0] in1_addr,
    input  logic [15:0] in0_data,
    input  logic [15:0] in1_data,
    input  logic [3:0]  in0_tag,
    input  logic [3:0]  in1_tag,
    output logic        in_ready,
    input  logic        flush,
    input  logic        mem_ready,
    output logic        isld,
    output logic        isst,
    output logic [15:0] aluresult,
    output logic [15:0] op2,
    output logic [3:0]  out_tag,
    output logic        addr_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] MAX_FILL = CNT_W'(DEPTH - 2);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] tail1;
    logic [CNT_W-1:0] count_q, count_d;

    // Only the load bit is kept: an accepted entry is exactly one of load/store.
    logic        isld_mem [DEPTH];
    logic [15:0] addr_mem [DEPTH];
    logic [15:0] data_mem [DEPTH];
    logic [3:0]  tag_mem  [DEPTH];

    logic not_empty, accept, deq, we0, we1;
    logic lane0_ok, lane1_ok, lane0_bad_addr, lane1_bad_addr;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q <= MAX_FILL);
    assign accept    = in_ready & ~flush;
    assign lane0_ok  = in0_valid & (in0_isld ^ in0_isst);
    assign lane1_ok  = in1_valid & (in1_isld ^ in1_isst);

`ifdef MEM_REQ_ADDR_CHECK_EN
    logic addr_err_q;

    assign lane0_bad_addr = (in0_addr[15:5] != '0);
    assign lane1_bad_addr = (in1_addr[15:5] != '0);
    assign addr_err       = addr_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= accept & ((lane0_ok & lane0_bad_addr) | (lane1_ok & lane1_bad_addr));
        end
    end
`else
    assign lane0_bad_addr = 1'b0;
    assign lane1_bad_addr = 1'b0;
    assign addr_err       = 1'b0;
`endif

    assign we0   = accept & lane0_ok & ~lane0_bad_addr;
    assign we1   = accept & lane1_ok & ~lane1_bad_addr;
    assign deq   = not_empty & mem_ready & ~flush;
    // Lane1 lands right behind lane0, or in lane0's slot when lane0 is absent.
    assign tail1 = tail_q + PTR_W'(we0);

    always_comb begin
        head_d  = head_q + PTR_W'(deq);
        tail_d  = tail_q + PTR_W'(we0) + PTR_W'(we1);
        count_d = count_q + CNT_W'(we0) + CNT_W'(we1) - CNT_W'(deq);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we0) begin
            isld_mem[tail_q] <= in0_isld;
            addr_mem[tail_q] <= in0_addr;
            data_mem[tail_q] <= in0_data;
            tag_mem[tail_q]  <= in0_tag;
        end
        if (we1) begin
            isld_mem[tail1] <= in1_isld;
            addr_mem[tail1] <= in1_addr;
            data_mem[tail1] <= in1_data;
            tag_mem[tail1]  <= in1_tag;
        end
    end

    // Storage is never reset; the count gates every head field.
    assign isld      = not_empty & isld_mem[head_q];
    assign isst      = not_empty & ~isld_mem[head_q];
    assign aluresult = not_empty ? addr_mem[head_q] : '0;
    assign op2       = not_empty ? data_mem[head_q] : '0;
    assign out_tag   = not_empty ? tag_mem[head_q]  : '0;

endmodule

// File: tb/tb_mem_req_queue.sv
// Directed self-checking bench for mem_req_queue (DEPTH=4); address-check case follows
// whether MEM_REQ_ADDR_CHECK_EN is defined.
module tb_mem_req_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in0_valid, in1_valid;
    logic        in0_isld, in0_isst, in1_isld, in1_isst;
    logic [15:0] in0_addr, in1_addr, in0_data, in1_data;
    logic [3:0]  in0_tag, in1_tag;
    logic        in_ready, flush, mem_ready;
    logic        isld, isst;
    logic [15:0] aluresult, op2;
    logic [3:0]  out_tag;
    logic        addr_err;

    int n_checks = 0;
    int n_pass   = 0;

    mem_req_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in1_valid(in1_valid),
        .in0_isld(in0_isld), .in0_isst(in0_isst),
        .in1_isld(in1_isld), .in1_isst(in1_isst),
        .in0_addr(in0_addr), .in1_addr(in1_addr),
        .in0_data(in0_data), .in1_data(in1_data),
        .in0_tag(in0_tag), .in1_tag(in1_tag),
        .in_ready(in_ready), .flush(flush), .mem_ready(mem_ready),
        .isld(isld), .isst(isst),
        .aluresult(aluresult), .op2(op2), .out_tag(out_tag),
        .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got 0x%0h ok", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        in0_valid = 0; in0_isld = 0; in0_isst = 0; in0_addr = 0; in0_data = 0; in0_tag = 0;
        in1_valid = 0; in1_isld = 0; in1_isst = 0; in1_addr = 0; in1_data = 0; in1_tag = 0;
    endtask

    task automatic lane0(input logic ld, input logic st, input logic [15:0] a,
                         input logic [15:0] d, input logic [3:0] t);
        in0_valid = 1; in0_isld = ld; in0_isst = st; in0_addr = a; in0_data = d; in0_tag = t;
    endtask

    task automatic lane1(input logic ld, input logic st, input logic [15:0] a,
                         input logic [15:0] d, input logic [3:0] t);
        in1_valid = 1; in1_isld = ld; in1_isst = st; in1_addr = a; in1_data = d; in1_tag = t;
    endtask

    initial begin
        int sent;
        int issued;
        rst = 1; flush = 0; mem_ready = 0;
        clear_lanes();

        // Reset state
        #2;
        check("rst_isld", isld, 0);
        check("rst_isst", isst, 0);
        check("rst_inready", in_ready, 1);
        check("rst_addr", aluresult, 0);
        check("rst_tag", out_tag, 0);
        check("rst_addrerr", addr_err, 0);
        #10 rst = 0;

        // Dual-issue ordering: lane0 store before lane1 load
        step();
        mem_ready = 1;
        lane0(0, 1, 16'd5, 16'h1234, 4'd1);
        lane1(1, 0, 16'd5, 16'h0000, 4'd2);
        step();
        clear_lanes();
        check("dual0_isst", isst, 1);
        check("dual0_isld", isld, 0);
        check("dual0_addr", aluresult, 5);
        check("dual0_data", op2, 16'h1234);
        check("dual0_tag", out_tag, 1);
        step();
        check("dual1_isld", isld, 1);
        check("dual1_addr", aluresult, 5);
        check("dual1_tag", out_tag, 2);
        step();
        check("dual_empty", isld | isst, 0);

        // Full / backpressure
        mem_ready = 0;
        lane0(1, 0, 16'd1, 16'd0, 4'd1);
        lane1(1, 0, 16'd2, 16'd0, 4'd2);
        step();
        check("full_rdy2", in_ready, 1);
        lane0(1, 0, 16'd3, 16'd0, 4'd3);
        lane1(1, 0, 16'd4, 16'd0, 4'd4);
        step();
        check("full_rdy4", in_ready, 0);
        lane0(1, 0, 16'd5, 16'd0, 4'd5);
        lane1(1, 0, 16'd6, 16'd0, 4'd6);
        step();
        clear_lanes();
        check("full_hold", in_ready, 0);
        check("full_head", out_tag, 1);
        mem_ready = 1;
        step();
        check("full_rdy3", in_ready, 0);
        check("full_head2", out_tag, 2);
        step();
        check("full_rdy_up", in_ready, 1);
        check("full_head3", out_tag, 3);
        step();
        check("full_head4", aluresult, 4);
        step();
        check("full_drained", isld | isst, 0);

        // Illegal op types dropped; lone lane1 takes the first slot
        mem_ready = 0;
        lane0(1, 1, 16'd9, 16'd0, 4'd9);
        lane1(0, 0, 16'd9, 16'd0, 4'd9);
        step();
        check("drop_empty", isld | isst, 0);
        clear_lanes();
        lane1(1, 0, 16'd7, 16'd0, 4'd7);
        step();
        clear_lanes();
        check("lone1_tag", out_tag, 7);
        check("lone1_rdy", in_ready, 1);
        mem_ready = 1;
        step();
        check("lone1_empty", isld, 0);

        // Wrap: 10 single-lane loads, alternating lanes, mem_ready toggling
        sent = 0;
        issued = 0;
        for (int cyc = 0; cyc < 80 && issued < 10; cyc++) begin
            mem_ready = cyc[0];
            if (isld && mem_ready) begin
                check("wrap_addr", aluresult, issued);
                issued++;
            end
            clear_lanes();
            if (sent < 10 && in_ready) begin
                if (sent % 2 == 0) lane0(1, 0, 16'(sent), 16'd0, 4'(sent));
                else               lane1(1, 0, 16'(sent), 16'd0, 4'(sent));
                sent++;
            end
            step();
        end
        clear_lanes();
        check("wrap_count", issued, 10);
        check("wrap_empty", isld | isst, 0);

        // Flush with lanes valid and 2 queued
        mem_ready = 0;
        lane0(1, 0, 16'd10, 16'd0, 4'd10);
        lane1(0, 1, 16'd11, 16'hBEEF, 4'd11);
        step();
        check("flush_pre", out_tag, 10);
        lane0(1, 0, 16'd12, 16'd0, 4'd12);
        lane1(1, 0, 16'd13, 16'd0, 4'd13);
        flush = 1;
        step();
        flush = 0;
        clear_lanes();
        check("flush_out", isld | isst, 0);
        check("flush_rdy", in_ready, 1);
        lane0(1, 0, 16'd14, 16'd0, 4'd14);
        step();
        clear_lanes();
        check("flush_next", out_tag, 14);
        mem_ready = 1;
        step();

        // Async reset mid-stream with 3 queued
        mem_ready = 0;
        lane0(1, 0, 16'd1, 16'd0, 4'd1);
        lane1(1, 0, 16'd2, 16'd0, 4'd2);
        step();
        lane0(0, 1, 16'd3, 16'd0, 4'd3);
        clear_lanes();
        lane0(0, 1, 16'd3, 16'd0, 4'd3);
        step();
        clear_lanes();
        check("mid_rdy3", in_ready, 0);
        check("mid_isld", isld, 1);
        #2 rst = 1;
        #1;
        check("mid_rst_cmd", isld | isst, 0);
        check("mid_rst_rdy", in_ready, 1);
        mem_ready = 1;
        step();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_cmd", isld | isst, 0);
        end

        // Address range check
        mem_ready = 0;
        lane0(1, 0, 16'h0020, 16'd0, 4'd3);
        step();
        clear_lanes();
`ifdef MEM_REQ_ADDR_CHECK_EN
        check("ac_err", addr_err, 1);
        check("ac_noissue", isld, 0);
        step();
        check("ac_err_clr", addr_err, 0);
        lane0(1, 0, 16'h001F, 16'd0, 4'd4);
        step();
        clear_lanes();
        check("ac_ok_issue", isld, 1);
        check("ac_ok_addr", aluresult, 16'h001F);
        check("ac_ok_err", addr_err, 0);
`else
        check("ac_err_tied", addr_err, 0);
        check("ac_issue", isld, 1);
        check("ac_addr", aluresult, 16'h0020);
`endif
        flush = 1;
        step();
        flush = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_req_queue.md
MEM_REQ_QUEUE -- requirements
Module: mem_req_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entry count (power of 2, >= 2).
REQ-002 SHALL have one clock, `clk`, with reset `rst` asynchronous and active-high.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports in0_valid, in1_valid  input  1 each  dual-issue lane request; lane0 is older.
REQ-006 SHALL have ports in0_isld, in0_isst, in1_isld, in1_isst  input  1 each  op type per lane.
REQ-007 SHALL have ports in0_addr, in1_addr  input  16 each  effective address (ALU result).
REQ-008 SHALL have ports in0_data, in1_data  input  16 each  store data (op2).
REQ-009 SHALL have ports in0_tag, in1_tag  input  4 each  destination/ROB tag.
REQ-010 SHALL have port in_ready  output  1  both lanes may enqueue this cycle.
REQ-011 SHALL have port flush  input  1  synchronous queue clear.
REQ-012 SHALL have port mem_ready  input  1  memory stage consumes head this cycle.
REQ-013 SHALL have ports isld, isst  output  1 each  memory-stage command.
REQ-014 SHALL have ports aluresult, op2  output  16 each  memory-stage address and store data.
REQ-015 SHALL have port out_tag  output  4  tag of head entry.
REQ-016 SHALL have port addr_err  output  1  one-cycle pulse on a rejected out-of-range address.

Function
REQ-017 SHALL hold an in-order FIFO of DEPTH entries {isld, addr, data, tag}, plus head/tail pointers (log2 DEPTH bits, wrapping modulo DEPTH) and a count (0..DEPTH).
REQ-018 SHALL drive in_ready = (DEPTH - count >= 2), from registered count only; same-cycle dequeue SHALL NOT raise it.
REQ-019 SHALL, on a rising edge with in_ready=1, enqueue lane0 then lane1 in that order; a lone lane1 SHALL occupy the first free slot.
REQ-020 SHALL ignore lanes presented while in_ready=0; upstream holds them.
REQ-021 SHALL drop, without enqueueing, any lane with isld=isst (both 0 or both 1).
REQ-022 SHALL drive isld/isst = head type AND (count!=0), and aluresult/op2/out_tag = head fields; when empty, isld=isst=0 and the data outputs are 0.
REQ-023 SHALL advance head on a rising edge when count!=0 and mem_ready=1.
REQ-024 SHALL have one-cycle latency: an entry enqueued into an empty queue at edge N SHALL appear on the outputs after edge N.
REQ-025 SHALL, on a simultaneous enqueue and dequeue, update count by (enqueued - dequeued) with no lost or duplicated entry, including across pointer wrap.
REQ-026 SHALL, when flush=1 at an edge, set count, head and tail to 0 and ignore that cycle's enqueues and dequeue; flush SHALL take priority over everything except rst.
REQ-027 SHALL keep stored fields unchanged once written until they are overwritten.

Reset
REQ-028 SHALL, while rst=1, immediately set count=0, head=0, tail=0, addr_err=0, isld=isst=0, aluresult=op2=0, out_tag=0 and in_ready=1.
REQ-029 SHALL, when rst is asserted mid-operation, discard all queued entries with no memory command issued afterwards.
REQ-030 SHALL leave storage contents undefined after reset, with outputs masked by count.

Configuration
REQ-031 SHALL, with macro MEM_REQ_ADDR_CHECK_EN defined, reject any lane whose addr[15:5] != 0 (outside the 32-word data memory): not enqueued, and addr_err registered high for exactly the next cycle (OR of both lanes).
REQ-032 SHALL, without MEM_REQ_ADDR_CHECK_EN, enqueue all addresses unchanged and tie addr_err to 0.

Verification
REQ-033 SHALL pass a reset test: rst pulse mid-stream with 3 entries queued -> isld=isst=0, in_ready=1 immediately; no command after release.
REQ-034 SHALL pass a dual-issue ordering test: lane0 st addr 5 data 0x1234 tag 1, lane1 ld addr 5 tag 2, mem_ready=1 -> isst/5/0x1234/tag1, then isld/5/tag2 the next cycle.
REQ-035 SHALL pass a full/backpressure test: DEPTH=4, mem_ready=0, two dual enqueues -> count=4, in_ready=0; a third pair is not accepted; mem_ready=1 for 2 cycles -> in_ready=1.
REQ-036 SHALL pass a wrap test: 10 single-lane loads (addr 0..9), mem_ready toggling 1/0 -> issued in order 0..9, no drop or duplicate.
REQ-037 SHALL pass a flush test: flush with lanes valid and 2 queued -> next cycle isld=isst=0, count=0; the flushing cycle's lanes are lost.
REQ-038 SHALL pass an address-check test, with the macro defined: lane0 ld addr 0x0020 -> not issued, addr_err=1 for one cycle; addr 0x001F -> issued normally.
